// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types, tap constants and saturation helpers for the CNN cell iterator
package cnn_pkg;

    // Sequencer phases: bias+control sum, feedback sum, state update, completion.
    typedef enum logic [2:0] {
        S_IDLE,
        S_BU,
        S_AY,
        S_UPD,
        S_DONE
    } state_t;

    localparam int TAPS   = 9;
    localparam int CENTRE = 4;

    // Clamp a wide signed value into the range of a width-bit two's-complement word.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Piecewise-linear cell output: clamp to [-ONE, +ONE] where ONE = 2^frac.
    function automatic logic signed [63:0] sat_1(input logic signed [63:0] v, input int frac);
        logic signed [63:0] one;
        one = 64'sd1 <<< frac;
        if (v > one) begin
            return one;
        end
        if (v < -one) begin
            return -one;
        end
        return v;
    endfunction

endpackage

// File: rtl/cnn_cell_iter_if.sv
// rtl/cnn_cell_iter_if.sv - control, template and status bundle for cnn_cell_iter
// Ports (master drives, slave = cell):
//   start, init_x, bias_i, n_iter, a_coef, b_coef, u_in, y_nbr : master -> cell
//   busy, done, iter_strobe, iter_cnt, x_out, y_out            : cell -> master
interface cnn_cell_iter_if
    import cnn_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int ITER_W = 8
) ();

    logic                          start;
    logic signed [WIDTH-1:0]       init_x;
    logic signed [WIDTH-1:0]       bias_i;
    logic        [ITER_W-1:0]      n_iter;
    logic        [TAPS*WIDTH-1:0]  a_coef;
    logic        [TAPS*WIDTH-1:0]  b_coef;
    logic        [TAPS*WIDTH-1:0]  u_in;
    logic        [TAPS*WIDTH-1:0]  y_nbr;

    logic                          busy;
    logic                          done;
    logic                          iter_strobe;
    logic        [ITER_W-1:0]      iter_cnt;
    logic signed [WIDTH-1:0]       x_out;
    logic signed [WIDTH-1:0]       y_out;

    modport master (
        output start, init_x, bias_i, n_iter, a_coef, b_coef, u_in, y_nbr,
        input  busy, done, iter_strobe, iter_cnt, x_out, y_out
    );

    modport slave (
        input  start, init_x, bias_i, n_iter, a_coef, b_coef, u_in, y_nbr,
        output busy, done, iter_strobe, iter_cnt, x_out, y_out
    );

endinterface

// File: rtl/cnn_cell_mac.sv
// rtl/cnn_cell_mac.sv - signed multiply, arithmetic >>> FRAC, accumulate with clear/enable
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clr_i          : restart the sum (same cycle as the first enabled term)
//   en_i           : add a_i*b_i >>> FRAC this cycle
//   a_i, b_i       : signed Q operands
//   sum_o          : running sum including this cycle's term (combinational)
module cnn_cell_mac #(
    parameter int WIDTH = 9,
    parameter int FRAC  = 4,
    parameter int ACC_W = 2 * WIDTH + 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] prod_sh;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   base;
    logic signed [ACC_W-1:0]   acc_q;

    always_comb begin
        prod    = a_i * b_i;
        prod_sh = prod >>> FRAC;
        term    = ACC_W'(prod_sh);
        base    = clr_i ? '0 : acc_q;
        sum_o   = en_i ? (base + term) : base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i || en_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

// File: rtl/cnn_cell_iter.sv
// rtl/cnn_cell_iter.sv - single CNN cell, forward-Euler iteration of dx/dt = -x + A*y + B*u + I
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : cnn_cell_iter_if.slave (start/templates in, busy/done/strobe/state out)
// One shared MAC walks the nine taps: once for B*u + I per run, then once per iteration for A*y.
module cnn_cell_iter
    import cnn_pkg::*;
#(
    parameter int WIDTH      = 9,
    parameter int FRAC       = 4,
    parameter int ITER_W     = 8,
    parameter int STEP_SHIFT = 2,
    parameter int ACC_W      = 2 * WIDTH + 5
) (
    input  logic              clk,
    input  logic              rst,
    cnn_cell_iter_if.slave    bus
);

    state_t                    state_q, state_d;
    logic [3:0]                tap_q, tap_d;
    logic signed [WIDTH-1:0]   x_q, y_q, bias_q;
    logic [TAPS*WIDTH-1:0]     a_q, b_q, u_q;
    logic [ITER_W-1:0]         n_iter_q, iter_cnt_q;
    logic signed [ACC_W-1:0]   bu_q, ay_q;
    logic                      strobe_q;

    logic                      accept;
    logic                      last_tap;
    logic [ITER_W:0]           iter_next;
    logic                      more_iter;

    logic signed [WIDTH-1:0]   a_tap, b_tap, u_tap, y_tap;
    logic signed [WIDTH-1:0]   mac_a, mac_b;
    logic                      mac_en, mac_clr;
    logic signed [ACC_W-1:0]   mac_sum;

    logic signed [ACC_W-1:0]   x_ext, diff, step, x_wide;
    logic signed [WIDTH-1:0]   x_upd, y_upd, y_init;

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign last_tap  = (tap_q == 4'(TAPS - 1));
    assign iter_next = {1'b0, iter_cnt_q} + (ITER_W + 1)'(1);
    assign more_iter = iter_next < {1'b0, n_iter_q};

    // Sequencer
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_BU;
                    tap_d   = '0;
                end
            end
            S_BU: begin
                if (last_tap) begin
                    tap_d   = '0;
                    state_d = (n_iter_q != '0) ? S_AY : S_DONE;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_AY: begin
                if (last_tap) begin
                    tap_d   = '0;
                    state_d = S_UPD;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_UPD:   state_d = more_iter ? S_AY : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Tap selection; the centre feedback tap uses this cell's own output, not y_nbr.
    always_comb begin
        a_tap = '0;
        b_tap = '0;
        u_tap = '0;
        y_tap = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (tap_q == 4'(k)) begin
                a_tap = a_q[k*WIDTH +: WIDTH];
                b_tap = b_q[k*WIDTH +: WIDTH];
                u_tap = u_q[k*WIDTH +: WIDTH];
                y_tap = (k == CENTRE) ? y_q : bus.y_nbr[k*WIDTH +: WIDTH];
            end
        end
    end

    assign mac_en  = (state_q == S_BU) || (state_q == S_AY);
    assign mac_clr = mac_en && (tap_q == 4'd0);
    assign mac_a   = (state_q == S_AY) ? a_tap : b_tap;
    assign mac_b   = (state_q == S_AY) ? y_tap : u_tap;

    cnn_cell_mac #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (mac_a),
        .b_i   (mac_b),
        .sum_o (mac_sum)
    );

    // Euler step in accumulator width; only the written-back state saturates.
    always_comb begin
        x_ext  = ACC_W'(x_q);
        diff   = ay_q + bu_q - x_ext;
        step   = diff >>> STEP_SHIFT;
        x_wide = x_ext + step;
        x_upd  = WIDTH'(sat_w(64'(x_wide), WIDTH));
        y_upd  = WIDTH'(sat_1(64'(x_upd), FRAC));
        y_init = WIDTH'(sat_1(64'(bus.init_x), FRAC));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tap_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            bias_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            u_q        <= '0;
            n_iter_q   <= '0;
            iter_cnt_q <= '0;
            bu_q       <= '0;
            ay_q       <= '0;
            strobe_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            // Strobe lands in the cycle the new x is visible.
            strobe_q <= (state_q == S_UPD);
            if (accept) begin
                x_q        <= bus.init_x;
                y_q        <= y_init;
                bias_q     <= bus.bias_i;
                n_iter_q   <= bus.n_iter;
                a_q        <= bus.a_coef;
                b_q        <= bus.b_coef;
                u_q        <= bus.u_in;
                iter_cnt_q <= '0;
            end
            if ((state_q == S_BU) && last_tap) begin
                bu_q <= ACC_W'(bias_q) + mac_sum;
            end
            if ((state_q == S_AY) && last_tap) begin
                ay_q <= mac_sum;
            end
            if (state_q == S_UPD) begin
                x_q        <= x_upd;
                y_q        <= y_upd;
                iter_cnt_q <= iter_next[ITER_W-1:0];
            end
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.iter_strobe = strobe_q;
    assign bus.iter_cnt    = iter_cnt_q;
    assign bus.x_out       = x_q;
    assign bus.y_out       = y_q;

endmodule

// File: tb/tb_cnn_cell_iter.sv
// tb/tb_cnn_cell_iter.sv - directed self-checking bench for cnn_cell_iter
module tb_cnn_cell_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   xs[$];
    int   lat;

    always #5 clk = ~clk;

    cnn_cell_iter_if #(.WIDTH(9), .ITER_W(8)) bus ();

    cnn_cell_iter #(
        .WIDTH(9), .FRAC(4), .ITER_W(8), .STEP_SHIFT(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int x0, input int bias, input int n);
        bus.a_coef = '0;
        bus.b_coef = '0;
        bus.u_in   = '0;
        bus.y_nbr  = '0;
        bus.init_x = 9'(x0);
        bus.bias_i = 9'(bias);
        bus.n_iter = 8'(n);
    endtask

    // Start a run from IDLE; cycle index 0 is the accept cycle. Optionally pokes start at cycle poke_at.
    task automatic do_run(input int limit, input int poke_at, output int latency);
        latency = -1;
        xs.delete();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            if (bus.iter_strobe) xs.push_back(int'(bus.x_out));
            if (bus.done) begin
                latency = c;
                break;
            end
            bus.start = (c == poke_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    function automatic int xs_at(input int i);
        return (xs.size() > i) ? xs[i] : -999;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        cfg(0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy",   int'(bus.busy), 0);
        check_eq("rst_done",   int'(bus.done), 0);
        check_eq("rst_strobe", int'(bus.iter_strobe), 0);
        check_eq("rst_iter",   int'(bus.iter_cnt), 0);
        check_eq("rst_x",      int'(bus.x_out), 0);
        check_eq("rst_y",      int'(bus.y_out), 0);
        rst = 1'b0;

        // Pure decay: x=5 -> 5 + (-5>>>2) = 3
        cfg(5, 0, 1);
        do_run(100, 0, lat);
        check_eq("decay_x",    int'(bus.x_out), 3);
        check_eq("decay_y",    int'(bus.y_out), 3);
        check_eq("decay_iter", int'(bus.iter_cnt), 1);
        check_eq("decay_lat",  lat, 20);

        // x=-3: 3>>>2 = 0, no change
        cfg(-3, 0, 1);
        do_run(100, 0, lat);
        check_eq("neg_x", int'(bus.x_out), -3);

        // Self feedback a4=2.0, with a stray start mid-run that must be ignored
        cfg(16, 0, 3);
        bus.a_coef[4*9 +: 9] = 9'sd32;
        do_run(100, 15, lat);
        check_eq("fb_nstrobe", xs.size(), 3);
        check_eq("fb_x1", xs_at(0), 20);
        check_eq("fb_x2", xs_at(1), 23);
        check_eq("fb_x3", xs_at(2), 25);
        check_eq("fb_y",   int'(bus.y_out), 16);
        check_eq("fb_lat", lat, 40);
        check_eq("fb_iter", int'(bus.iter_cnt), 3);
        repeat (3) @(negedge clk);
        check_eq("hold_x",    int'(bus.x_out), 25);
        check_eq("hold_iter", int'(bus.iter_cnt), 3);
        check_eq("hold_busy", int'(bus.busy), 0);

        // Large B*u + I saturates x at +255, y at +ONE
        cfg(0, 255, 1);
        bus.b_coef[4*9 +: 9] = 9'sd127;
        bus.u_in[4*9 +: 9]   = 9'sd127;
        do_run(100, 0, lat);
        check_eq("sat_x", int'(bus.x_out), 255);
        check_eq("sat_y", int'(bus.y_out), 16);

        // Zero iterations
        cfg(-40, 0, 0);
        do_run(100, 0, lat);
        check_eq("n0_lat",    lat, 10);
        check_eq("n0_x",      int'(bus.x_out), -40);
        check_eq("n0_y",      int'(bus.y_out), -16);
        check_eq("n0_strobe", xs.size(), 0);
        check_eq("n0_iter",   int'(bus.iter_cnt), 0);

        // Start raised in the DONE cycle is ignored, then taken in the following IDLE cycle
        bus.start = 1'b1;
        @(negedge clk);
        check_eq("donestart_idle", int'(bus.busy), 0);
        @(negedge clk);
        check_eq("donestart_accept", int'(bus.busy), 1);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset in the middle of an AY phase
        cfg(16, 0, 3);
        bus.a_coef[4*9 +: 9] = 9'sd32;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        check_eq("mid_busy", int'(bus.busy), 1);
        check_eq("mid_x",    int'(bus.x_out), 16);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy",   int'(bus.busy), 0);
        check_eq("midrst_done",   int'(bus.done), 0);
        check_eq("midrst_strobe", int'(bus.iter_strobe), 0);
        check_eq("midrst_iter",   int'(bus.iter_cnt), 0);
        check_eq("midrst_x",      int'(bus.x_out), 0);
        check_eq("midrst_y",      int'(bus.y_out), 0);

        // Reset and start together: start lost
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rststart_busy", int'(bus.busy), 0);

        // Normal run after reset
        cfg(5, 0, 1);
        do_run(100, 0, lat);
        check_eq("post_x",   int'(bus.x_out), 3);
        check_eq("post_lat", lat, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cnn_cell_iter.md
CNN_CELL_ITER -- requirements
Module: cnn_cell_iter

Interface
REQ-001 Parameter WIDTH, default 9: signed two's-complement width of all data ports; Q format with FRAC fraction bits.
REQ-002 Parameter FRAC, default 4: fraction bits; unity ONE = 2^FRAC.
REQ-003 Parameter ITER_W, default 8: width of n_iter and iter_cnt.
REQ-004 Parameter STEP_SHIFT, default 2: Euler step h = 2^-STEP_SHIFT.
REQ-005 Parameter ACC_W, default 2*WIDTH+5: accumulator width.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request a run; sampled only in IDLE.
REQ-009 init_x  in  WIDTH  initial state x(0).
REQ-010 bias_i  in  WIDTH  bias I.
REQ-011 n_iter  in  ITER_W  number of Euler iterations.
REQ-012 a_coef, b_coef  in  9*WIDTH each  feedback/control templates; tap k in bits [k*WIDTH +: WIDTH]; tap 4 is centre.
REQ-013 u_in  in  9*WIDTH  neighbourhood inputs U.
REQ-014 y_nbr  in  9*WIDTH  neighbour outputs Y; tap 4 ignored, own y used instead.
REQ-015 busy  out  1  high from cycle after start accept until done cycle inclusive.
REQ-016 done  out  1  one-cycle pulse at run completion.
REQ-017 iter_strobe  out  1  one-cycle pulse per completed iteration.
REQ-018 iter_cnt  out  ITER_W  completed iterations in current run.
REQ-019 x_out, y_out  out  WIDTH each  current state x and output y.

Function
REQ-020 FSM states IDLE, BU, AY, UPD, DONE; IDLE->BU on start; BU runs 9 cycles (taps 0..8); BU->AY if n_iter!=0 else DONE; AY runs 9 cycles; AY->UPD; UPD->AY if iter_cnt+1<n_iter else DONE; DONE->IDLE after 1 cycle.
REQ-021 Start accept: init_x, bias_i, n_iter, a_coef, b_coef, u_in registered; x_out<=init_x, y_out<=sat1(init_x), iter_cnt<=0.
REQ-022 BU phase: BU = I + sum_k (b_k*u_k >>> FRAC), computed once per run, held.
REQ-023 AY phase: AY = sum_k (a_k*y_k >>> FRAC), y_nbr sampled live per tap cycle, y_4 = current y_out.
REQ-024 UPD: x <= satW(x + ((-x + AY + BU) >>> STEP_SHIFT)); y <= sat1(new x); iter_cnt increments; iter_strobe pulses.
REQ-025 All shifts arithmetic (floor toward -inf); no rounding.
REQ-026 Accumulation in ACC_W bits, never wraps; saturation only at x writeback.
REQ-027 satW clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat1 clamps to [-ONE, +ONE].
REQ-028 Latency start-accept to done = 10 + 10*n_iter cycles; n_iter=0 gives done 10 cycles after accept with x_out=init_x.
REQ-029 start while busy ignored; x_out/y_out/iter_cnt hold after DONE until next accept.
REQ-030 start asserted in the DONE cycle ignored; accepted earliest the following IDLE cycle.

Reset
REQ-031 rst overrides everything, including mid-run: state IDLE, busy=0, done=0, iter_strobe=0, iter_cnt=0, x_out=0, y_out=0, accumulators cleared.
REQ-032 rst and start in same cycle: reset wins; start lost.

Structure
REQ-033 Package cnn_pkg holds FSM state enum, tap count 9, centre index 4, and satW/sat1 functions.
REQ-034 One sub-module cnn_cell_mac: signed multiply, >>> FRAC, accumulate, with clear and enable; instantiated once, shared by BU and AY phases.

Verification (WIDTH=9, FRAC=4, STEP_SHIFT=2)
REQ-035 A=B=0, I=0, init_x=5, n_iter=1 -> x_out=3 (dx=-5>>>2=-2), y_out=3; init_x=-3 -> x_out=-3.
REQ-036 a_4=32, others 0, B=0, I=0, init_x=16, n_iter=3 -> x_out 20,23,25 at successive iter_strobe; y_out=16; done 40 cycles after accept.
REQ-037 b_4=127, u_4=127, I=255, init_x=0, n_iter=1 -> x_out=255 (saturated), y_out=16.
REQ-038 n_iter=0, init_x=-40 -> done 10 cycles after accept, x_out=-40, y_out=-16, no iter_strobe.
REQ-039 start pulsed during run -> ignored; rst asserted mid-AY -> next cycle all outputs 0, IDLE, new start accepted normally.
